// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard unit: load-use and branch-in-ID operand hazards with a multi-cycle stall counter.
// Optional stall/event counters are built when HZD_STALL_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = $clog2(LOAD_LAT + 2)
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  IFID_Valid,
  input  logic [REG_ADDR_W-1:0] IFIDRs,
  input  logic [REG_ADDR_W-1:0] IFIDRt,
  input  logic                  IFID_UsesRt,
  input  logic                  IFID_Branch,
  input  logic                  IDEX_MemRead,
  input  logic                  IDEX_RegWrite,
  input  logic [REG_ADDR_W-1:0] IDEXRd,
  input  logic                  EXMEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EXMEMRd,
  output logic                  IF_IDWrite,
  output logic                  PCWrite,
  output logic                  MuxSel,
  output logic                  Stalling
`ifdef HZD_STALL_CNT_EN
  ,
  output logic [31:0]           StallCount,
  output logic [15:0]           HazardEvents
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [CNT_W-1:0] LAT  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] LAT1 = CNT_W'(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] need;
  logic             m_ex, m_mem;
  logic             stall;

  // Bubbles and $0 never create a dependency; Rt only counts when it is actually read.
  assign m_ex  = IFID_Valid && (IDEXRd != '0) &&
                 ((IFIDRs == IDEXRd) || (IFID_UsesRt && (IFIDRt == IDEXRd)));
  assign m_mem = IFID_Valid && (EXMEMRd != '0) &&
                 ((IFIDRs == EXMEMRd) || (IFID_UsesRt && (IFIDRt == EXMEMRd)));

  always_comb begin
    need = '0;
    if (IDEX_MemRead && m_ex && (LAT > need))
      need = LAT;
    if (IFID_Branch && IDEX_MemRead && m_ex && (LAT1 > need))
      need = LAT1;
    if (IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && m_ex && (ONE > need))
      need = ONE;
    if (IFID_Branch && EXMEM_MemRead && m_mem && (LAT > need))
      need = LAT;
  end

  assign stall = (state == STALL) || ((state == IDLE) && (need != '0));

  // The first stall cycle is spent in IDLE; STALL covers the remaining need-1 cycles.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    case (state)
      IDLE: begin
        if (need >= CNT_W'(2)) begin
          state_n = STALL;
          rem_n   = need - ONE;
        end
      end
      STALL: begin
        if (rem == ONE) begin
          state_n = IDLE;
          rem_n   = '0;
        end else begin
          rem_n = rem - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        rem_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  assign IF_IDWrite = !stall || init;
  assign PCWrite    = !stall || init;
  assign MuxSel     = stall && !init;
  assign Stalling   = (state == STALL);

`ifdef HZD_STALL_CNT_EN
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      StallCount   <= '0;
      HazardEvents <= '0;
    end else begin
      if (stall && (StallCount != '1))
        StallCount <= StallCount + 32'd1;
      if ((state == IDLE) && (need != '0) && (HazardEvents != '1))
        HazardEvents <= HazardEvents + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (LOAD_LAT 1/2/3) share one stimulus bus.
// Output vector per instance is {PCWrite, IF_IDWrite, MuxSel, Stalling}.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       init;
  logic       IFID_Valid, IFID_UsesRt, IFID_Branch;
  logic [4:0] IFIDRs, IFIDRt, IDEXRd, EXMEMRd;
  logic       IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
  logic [2:0] pcw, ifw, mux, stl;
`ifdef HZD_STALL_CNT_EN
  logic [31:0] sc [3];
  logic [15:0] he [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  localparam logic [3:0] RUN  = 4'b1100;
  localparam logic [3:0] STL0 = 4'b0010;
  localparam logic [3:0] STL1 = 4'b0011;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_LAT(g + 1)) u_dut (
      .clk           (clk),
      .init          (init),
      .IFID_Valid    (IFID_Valid),
      .IFIDRs        (IFIDRs),
      .IFIDRt        (IFIDRt),
      .IFID_UsesRt   (IFID_UsesRt),
      .IFID_Branch   (IFID_Branch),
      .IDEX_MemRead  (IDEX_MemRead),
      .IDEX_RegWrite (IDEX_RegWrite),
      .IDEXRd        (IDEXRd),
      .EXMEM_MemRead (EXMEM_MemRead),
      .EXMEMRd       (EXMEMRd),
      .IF_IDWrite    (ifw[g]),
      .PCWrite       (pcw[g]),
      .MuxSel        (mux[g]),
      .Stalling      (stl[g])
`ifdef HZD_STALL_CNT_EN
      ,
      .StallCount    (sc[g]),
      .HazardEvents  (he[g])
`endif
    );
  end

  function automatic logic [3:0] o(input int i);
    return {pcw[i], ifw[i], mux[i], stl[i]};
  endfunction

  task automatic clr();
    IFID_Valid = 1'b0; IFID_UsesRt = 1'b0; IFID_Branch = 1'b0;
    IFIDRs = '0; IFIDRt = '0; IDEXRd = '0; EXMEMRd = '0;
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; EXMEM_MemRead = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    clr();
    repeat (4) nxt();
  endtask

  // lw $rd in EX, ID instruction reads rs (and rt if uses_rt)
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt, input logic uses_rt);
    clr();
    IFID_Valid = 1'b1; IFIDRs = rs; IFIDRt = rt; IFID_UsesRt = uses_rt;
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEXRd = rd;
  endtask

  task automatic test_reset();
    init = 1'b1;
    load_use(5'd5, 5'd5, 5'd0, 1'b0);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o(i) !== RUN) begin
        errors++;
        $display("FAIL reset_out[%0d] got %b want %b", i, o(i), RUN);
      end
`ifdef HZD_STALL_CNT_EN
      checks++;
      if (sc[i] !== 32'd0 || he[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_cnt[%0d] got %0d/%0d want 0/0", i, sc[i], he[i]);
      end
`endif
    end
    @(posedge clk); #1;
    init = 1'b0;
    settle();
  endtask

  task automatic test_load_use_lat1();
    logic [3:0] exp [2];
    exp[0] = STL0; exp[1] = RUN;
    load_use(5'd5, 5'd5, 5'd0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (o(0) !== exp[c]) begin
        errors++;
        $display("FAIL lu_lat1 cyc%0d got %b want %b", c, o(0), exp[c]);
      end
      nxt();
      clr();
    end
    settle();
  endtask

  task automatic test_no_false_stall();
    for (int v = 0; v < 3; v++) begin
      case (v)
        0: load_use(5'd0, 5'd0, 5'd0, 1'b1);
        1: load_use(5'd5, 5'd3, 5'd5, 1'b0);
        default: begin load_use(5'd5, 5'd5, 5'd5, 1'b1); IFID_Valid = 1'b0; end
      endcase
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++;
        if (o(0) !== RUN || o(2) !== RUN) begin
          errors++;
          $display("FAIL no_stall v%0d cyc%0d got %b/%b want %b", v, c, o(0), o(2), RUN);
        end
        nxt();
      end
    end
    settle();
  endtask

  task automatic test_load_use_lat3();
    logic [3:0] exp [4];
    exp[0] = STL0; exp[1] = STL1; exp[2] = STL1; exp[3] = RUN;
    load_use(5'd9, 5'd3, 5'd9, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o(2) !== exp[c]) begin
        errors++;
        $display("FAIL lu_lat3 cyc%0d got %b want %b", c, o(2), exp[c]);
      end
      nxt();
      if (c == 1) load_use(5'd3, 5'd3, 5'd9, 1'b1);
      else clr();
    end
    settle();
  endtask

  // beq $7,$8 in ID on the LOAD_LAT=2 instance; sel picks the producer
  task automatic test_branch();
    logic [3:0] exp [3][4];
    exp[0][0] = STL0; exp[0][1] = STL1; exp[0][2] = STL1; exp[0][3] = RUN;
    exp[1][0] = STL0; exp[1][1] = RUN;  exp[1][2] = RUN;  exp[1][3] = RUN;
    exp[2][0] = STL0; exp[2][1] = STL1; exp[2][2] = RUN;  exp[2][3] = RUN;
    for (int s = 0; s < 3; s++) begin
      clr();
      IFID_Valid = 1'b1; IFID_Branch = 1'b1; IFID_UsesRt = 1'b1;
      IFIDRs = 5'd7; IFIDRt = 5'd8;
      case (s)
        0: begin IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEXRd = 5'd7; end
        1: begin IDEX_RegWrite = 1'b1; IDEXRd = 5'd7; end
        default: begin EXMEM_MemRead = 1'b1; EXMEMRd = 5'd7; end
      endcase
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (o(1) !== exp[s][c]) begin
          errors++;
          $display("FAIL branch s%0d cyc%0d got %b want %b", s, c, o(1), exp[s][c]);
        end
        nxt();
        clr();
      end
      settle();
    end
  endtask

  task automatic test_max_and_dual_match();
    logic [3:0] exp [4];
    exp[0] = STL0; exp[1] = STL1; exp[2] = STL1; exp[3] = RUN;
    clr();
    IFID_Valid = 1'b1; IFID_Branch = 1'b1; IFID_UsesRt = 1'b1;
    IFIDRs = 5'd7; IFIDRt = 5'd7;
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEXRd = 5'd7;
    EXMEM_MemRead = 1'b1; EXMEMRd = 5'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o(1) !== exp[c]) begin
        errors++;
        $display("FAIL max_rule cyc%0d got %b want %b", c, o(1), exp[c]);
      end
      nxt();
      clr();
    end
    settle();
    load_use(5'd4, 5'd4, 5'd4, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o(2) !== exp[c]) begin
        errors++;
        $display("FAIL dual_match cyc%0d got %b want %b", c, o(2), exp[c]);
      end
      nxt();
      clr();
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [5];
    exp[0] = STL0; exp[1] = STL1; exp[2] = STL0; exp[3] = STL1; exp[4] = RUN;
    load_use(5'd6, 5'd6, 5'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o(1) !== exp[c]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got %b want %b", c, o(1), exp[c]);
      end
      nxt();
      if (c >= 2) clr();
    end
    settle();
  endtask

  task automatic test_init_mid_stall();
    load_use(5'd9, 5'd9, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (o(2) !== STL0) begin
      errors++;
      $display("FAIL init_pre cyc0 got %b want %b", o(2), STL0);
    end
    nxt();
    clr();
    @(negedge clk);
    checks++;
    if (o(2) !== STL1) begin
      errors++;
      $display("FAIL init_pre cyc1 got %b want %b", o(2), STL1);
    end
    #1 init = 1'b1;
    #1;
    checks++;
    if (o(2) !== RUN) begin
      errors++;
      $display("FAIL init_async got %b want %b", o(2), RUN);
    end
    nxt();
    init = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (o(2) !== RUN) begin
        errors++;
        $display("FAIL init_after cyc%0d got %b want %b", c, o(2), RUN);
      end
      nxt();
    end
    settle();
  endtask

`ifdef HZD_STALL_CNT_EN
  task automatic test_counters();
    init = 1'b1;
    #2 init = 1'b0;
    nxt();
    for (int e = 0; e < 2; e++) begin
      load_use(5'd5, 5'd5, 5'd0, 1'b0);
      nxt();
      clr();
      repeat (2) nxt();
    end
    @(negedge clk);
    checks++;
    if (sc[1] !== 32'd4 || he[1] !== 16'd2) begin
      errors++;
      $display("FAIL counters got %0d/%0d want 4/2", sc[1], he[1]);
    end
    init = 1'b1;
    #1;
    checks++;
    if (sc[1] !== 32'd0 || he[1] !== 16'd0) begin
      errors++;
      $display("FAIL counters_clr got %0d/%0d want 0/0", sc[1], he[1]);
    end
    nxt();
    init = 1'b0;
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use_lat1();
    test_no_false_stall();
    test_load_use_lat3();
    test_branch();
    test_max_and_dual_match();
    test_back_to_back();
    test_init_mid_stall();
`ifdef HZD_STALL_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the load-use hazard detector in the ID stage of the 5-stage MIPS32 pipeline.
- Detects load-use hazards and branch-in-ID operand hazards, and holds a multi-cycle stall with an internal down-counter, so memories with latency above one cycle are supported.
- Suppresses false stalls on register $0, on I-type instructions that do not read Rt, and on invalid (bubble) IF/ID entries.
- Drives PC/IF_ID write enables and the control-zeroing mux select.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- LOAD_LAT, 1, bubble cycles needed between a load in EX and a dependent instruction in EX (≥1).
- CNT_W, $clog2(LOAD_LAT+2), stall down-counter width.

Ports:
- clk  in  1  pipeline clock.
- init  in  1  reset, asynchronous, active-high.
- IFID_Valid  in  1  IF/ID holds a real instruction.
- IFIDRs  in  REG_ADDR_W  ID-stage Rs.
- IFIDRt  in  REG_ADDR_W  ID-stage Rt.
- IFID_UsesRt  in  1  ID instruction reads Rt (R-type, store, beq/bne).
- IFID_Branch  in  1  ID instruction is a branch resolved in ID.
- IDEX_MemRead  in  1  EX-stage instruction is a load.
- IDEX_RegWrite  in  1  EX-stage instruction writes the register file.
- IDEXRd  in  REG_ADDR_W  EX-stage destination (post RegDst mux).
- EXMEM_MemRead  in  1  MEM-stage instruction is a load.
- EXMEMRd  in  REG_ADDR_W  MEM-stage destination.
- IF_IDWrite  out  1  IF/ID register write enable.
- PCWrite  out  1  PC write enable.
- MuxSel  out  1  1 = zero ID/EX control (insert bubble).
- Stalling  out  1  FSM in STALL state.

Behaviour:
- stall = (state==STALL) | (state==IDLE & need>0).
- IF_IDWrite = PCWrite = ~stall | init; MuxSel = stall & ~init.
- Under init: IF_IDWrite=1, PCWrite=1, MuxSel=0, Stalling=0, state=IDLE, rem=0.
- Operand match:
  - mRs(X) = IFID_Valid & IFIDRs==X & X!=0.
  - mRt(X) = IFID_Valid & IFID_UsesRt & IFIDRt==X & X!=0.
  - m(X) = mRs(X) | mRt(X).
- Required stall cycles in IDLE; need = maximum of the applicable terms, else 0:
  - IDEX_MemRead & m(IDEXRd) → LOAD_LAT.
  - IFID_Branch & IDEX_MemRead & m(IDEXRd) → LOAD_LAT+1.
  - IFID_Branch & IDEX_RegWrite & ~IDEX_MemRead & m(IDEXRd) → 1.
  - IFID_Branch & EXMEM_MemRead & m(EXMEMRd) → LOAD_LAT.
- FSM:
  - IDLE, need==0: no stall; stay.
  - IDLE, need==1: stall this cycle; stay IDLE.
  - IDLE, need≥2: stall this cycle; rem←need-1; →STALL.
  - STALL: stall asserted and hazard inputs ignored. If rem==1 →IDLE, else rem←rem-1.
- A hazard detected at cycle T with need=N asserts stall in cycles T..T+N-1 exactly, then returns to combinational evaluation at T+N. Re-detection at T+N is legal and starts a new sequence.
- Stalling=1 exactly while state==STALL (registered).
- init asserted mid-STALL: immediately (asynchronously) clears to IDLE and outputs go non-stall; no residual stall after release.
- Simultaneous Rs and Rt matches: single sequence, not additive.
- IDEXRd==EXMEMRd with both terms active: max rule applies.

Optional Feature:
- Macro: HZD_STALL_CNT_EN.
- When defined:
  - Adds output StallCount (out, 32) counting every cycle with stall=1 & ~init.
  - Cleared by init; saturates at 32'hFFFF_FFFF.
  - Adds output HazardEvents (out, 16) incremented once per IDLE→stall detection; saturating.
- When undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1; lw $5 in EX (IDEX_MemRead=1, IDEXRd=5); add in ID with IFIDRs=5 → stall one cycle (PCWrite=0, IF_IDWrite=0, MuxSel=1); next cycle ID/EX bubble, all non-stall; Stalling stays 0.
- Same as above but IDEXRd=0, or IFIDRt=5 with IFID_UsesRt=0, or IFID_Valid=0 → no stall in any cycle.
- LOAD_LAT=3; load-use on Rt=9 → stall exactly 3 cycles; Stalling=1 in cycles 2–3; hazard inputs toggled during cycles 2–3 have no effect; PCWrite=1 in cycle 4.
- LOAD_LAT=2; beq in ID reading $7:
  - With lw $7 in EX → 3 stall cycles.
  - With add $7 in EX → 1 stall cycle.
  - With lw $7 in MEM only → 2 stall cycles.
- LOAD_LAT=3; assert init during the 2nd stall cycle → outputs non-stall within the same cycle, Stalling=0; after release with no hazard, no stall.
- With HZD_STALL_CNT_EN: two load-use events at LOAD_LAT=2 → StallCount=4, HazardEvents=2; init clears both to 0.
